// File: rtl/eth_tx_pkg.sv
// eth_tx_pkg: shared types and constants for the Ethernet transmit sequencer.
//   tx_sched_state_t : frame scheduler states
//   IFG_BYTES, PAUSE_QUANTUM_BITS, MAX_FRAME_BYTES : 802.3 timing constants
//   PAUSE_CNT_W      : width of the pause down-counter (16-bit quanta << log2(cycles/quantum))
package eth_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2,
        IFG    = 2'd3
    } tx_sched_state_t;

    localparam int IFG_BYTES          = 12;
    localparam int PAUSE_QUANTUM_BITS = 512;
    localparam int MAX_FRAME_BYTES    = 1522;

    // 16-bit quanta times 64 cycles per quantum at 8 bits per cycle
    localparam int PAUSE_CNT_W = 16 + $clog2(PAUSE_QUANTUM_BITS / 8);

endpackage

// File: rtl/tx_pause_timer.sv
// tx_pause_timer: 802.3x PAUSE down-counter.
//   eth_tx_clk   in  : clock
//   eth_rst      in  : synchronous active-high reset
//   pause_valid  in  : load strobe for pause_quanta
//   pause_quanta in  : pause time in quanta (0 cancels)
//   paused       out : remaining pause time is non-zero
module tx_pause_timer
    import eth_tx_pkg::*;
#(
    parameter int QUANTUM_CYCLES = 64
) (
    input  logic        eth_tx_clk,
    input  logic        eth_rst,
    input  logic        pause_valid,
    input  logic [15:0] pause_quanta,
    output logic        paused
);

    localparam int SHIFT = $clog2(QUANTUM_CYCLES);

    logic [PAUSE_CNT_W-1:0] pause_cnt;

    // A reload always overwrites the remaining count, so quanta=0 clears at once.
    always_ff @(posedge eth_tx_clk) begin
        if (eth_rst) begin
            pause_cnt <= '0;
        end else if (pause_valid) begin
            pause_cnt <= PAUSE_CNT_W'(pause_quanta) << SHIFT;
        end else if (pause_cnt != '0) begin
            pause_cnt <= pause_cnt - PAUSE_CNT_W'(1);
        end
    end

    assign paused = (pause_cnt != '0);

endmodule

// File: rtl/tx_frame_sched.sv
// tx_frame_sched: counts frames queued in the TX FIFO and issues one tx_start
// per frame, enforcing the inter-frame gap and honouring PAUSE while idle.
//   eth_tx_clk, eth_rst (sync, active high)
//   pct_qued     in  : frame fully queued          pct_txed in : frame on the wire
//   pause_valid  in  : pause_quanta valid           pause_quanta in [15:0]
//   tx_start     out : start pulse                  tx_busy  out : START/ACTIVE/IFG
//   paused       out : pause active                 pending_cnt out [CNT_W-1:0]
//   overflow, proto_err, timeout out : sticky error flags
// Optional macro TX_WATCHDOG_EN adds an ACTIVE-state watchdog driving timeout;
// without it timeout is tied low and ACTIVE waits for pct_txed indefinitely.
//
// state  | meaning
// IDLE   | waiting for a pending frame while not paused
// START  | tx_start pulse for one cycle
// ACTIVE | frame on the wire, waiting for pct_txed
// IFG    | inter-frame gap countdown
module tx_frame_sched
    import eth_tx_pkg::*;
#(
    parameter int CNT_W                = 4,
    parameter int IFG_CYCLES           = IFG_BYTES,
    parameter int PAUSE_QUANTUM_CYCLES = PAUSE_QUANTUM_BITS / 8,
    parameter int MAX_FRAME_CYCLES     = MAX_FRAME_BYTES + 8
) (
    input  logic             eth_tx_clk,
    input  logic             eth_rst,
    input  logic             pct_qued,
    input  logic             pct_txed,
    input  logic             pause_valid,
    input  logic [15:0]      pause_quanta,
    output logic             tx_start,
    output logic             tx_busy,
    output logic             paused,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             proto_err,
    output logic             timeout
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES - 1);

    // The watchdog counter is 11 bits wide.
    if (MAX_FRAME_CYCLES < 1 || MAX_FRAME_CYCLES > 2047) begin : g_bad_max_frame
        $error("MAX_FRAME_CYCLES must fit the 11-bit watchdog counter");
    end

    tx_sched_state_t  state;
    logic [GAP_W-1:0] gap_cnt;

    tx_pause_timer #(
        .QUANTUM_CYCLES(PAUSE_QUANTUM_CYCLES)
    ) u_pause (
        .eth_tx_clk  (eth_tx_clk),
        .eth_rst     (eth_rst),
        .pause_valid (pause_valid),
        .pause_quanta(pause_quanta),
        .paused      (paused)
    );

    // tx_start is only high in START, which the FSM enters only with pending_cnt != 0,
    // so the decrement can never underflow.
    always_ff @(posedge eth_tx_clk) begin
        if (eth_rst) begin
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else begin
            case ({pct_qued, tx_start})
                2'b10: begin
                    if (pending_cnt == '1) overflow <= 1'b1;
                    else                   pending_cnt <= pending_cnt + CNT_W'(1);
                end
                2'b01:   pending_cnt <= pending_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

`ifdef TX_WATCHDOG_EN
    localparam logic [10:0] WD_LAST = 11'(MAX_FRAME_CYCLES - 1);
    logic [10:0] wd_cnt;
`endif

    always_ff @(posedge eth_tx_clk) begin
        if (eth_rst) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            tx_start  <= 1'b0;
            tx_busy   <= 1'b0;
            proto_err <= 1'b0;
`ifdef TX_WATCHDOG_EN
            wd_cnt    <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            if (pct_txed && state != ACTIVE) proto_err <= 1'b1;

            case (state)
                IDLE: begin
                    // Registered paused: a same-cycle pause_valid does not block this start.
                    if (pending_cnt != '0 && !paused) begin
                        state    <= START;
                        tx_start <= 1'b1;
                        tx_busy  <= 1'b1;
                    end
                end
                START: begin
                    state <= ACTIVE;
`ifdef TX_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                ACTIVE: begin
                    if (pct_txed) begin
                        state   <= IFG;
                        gap_cnt <= GAP_LOAD;
`ifdef TX_WATCHDOG_EN
                    end else if (wd_cnt == WD_LAST) begin
                        // Limit reached on this ACTIVE cycle without completion.
                        state   <= IFG;
                        gap_cnt <= GAP_LOAD;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 11'd1;
`endif
                    end
                end
                IFG: begin
                    if (gap_cnt == '0) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

`ifndef TX_WATCHDOG_EN
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tx_frame_sched.sv
module tb_tx_frame_sched;

    logic        clk = 1'b0;
    logic        eth_rst;
    logic        pct_qued, pct_txed, pause_valid;
    logic [15:0] pause_quanta;
    logic        tx_start, tx_busy, paused, overflow, proto_err, timeout;
    logic [3:0]  pending_cnt;

    always #5 clk = ~clk;

    tx_frame_sched dut (
        .eth_tx_clk  (clk),
        .eth_rst     (eth_rst),
        .pct_qued    (pct_qued),
        .pct_txed    (pct_txed),
        .pause_valid (pause_valid),
        .pause_quanta(pause_quanta),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .paused      (paused),
        .pending_cnt (pending_cnt),
        .overflow    (overflow),
        .proto_err   (proto_err),
        .timeout     (timeout)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_q[$];     // expected tx_start cycles

    typedef struct {
        logic        qued, txed, pv;
        logic [15:0] quanta;
        int          start_ofs;
        int          e_pend;
        logic        e_busy, e_paused, e_ovf, e_perr;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic q, logic t, logic pv, logic [15:0] qu, int ofs,
                                int pend, logic busy, logic pa, logic ovf, logic perr);
        vec_t v;
        v.qued = q; v.txed = t; v.pv = pv; v.quanta = qu; v.start_ofs = ofs;
        v.e_pend = pend; v.e_busy = busy; v.e_paused = pa; v.e_ovf = ovf; v.e_perr = perr;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance one cycle and sample #1 after the edge; the scoreboard checks tx_start here.
    task automatic tick();
        int e;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_tx_start: got pulse at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                chk("tx_start_cycle", cyc, e);
            end
        end else if (exp_q.size() != 0 && exp_q[0] < cyc) begin
            e = exp_q.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL missed_tx_start: got none by cycle %0d expected at %0d", cyc, e);
        end
    endtask

    task automatic clear_inputs();
        pct_qued = 0; pct_txed = 0; pause_valid = 0; pause_quanta = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        eth_rst = 1;
        tick();
        tick();
        eth_rst = 0;
        exp_q.delete();
    endtask

    initial begin
        int n, t, s, p, hi;
        clear_inputs();
        eth_rst = 1;
        reset_dut();

        chk("rst_tx_start", tx_start, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_paused", paused, 0);
        chk("rst_pending", pending_cnt, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_timeout", timeout, 0);

        // Table: long pause holds IDLE while the counter saturates, then cancel and start.
        tbl[0] = mk(0, 0, 1, 16'd100, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 15; i++) tbl[i] = mk(1, 0, 0, 16'd0, 0, i, 0, 1, 0, 0);
        tbl[16] = mk(1, 0, 0, 16'd0, 0, 15, 0, 1, 1, 0);
        tbl[17] = mk(0, 1, 0, 16'd0, 0, 15, 0, 1, 1, 1);   // pct_txed in IDLE
        tbl[18] = mk(0, 0, 1, 16'd0, 2, 15, 0, 0, 1, 1);   // quanta 0 cancels
        tbl[19] = mk(0, 0, 0, 16'd0, 0, 15, 1, 0, 1, 1);   // START
        tbl[20] = mk(1, 0, 0, 16'd0, 0, 15, 1, 0, 1, 1);   // qued with tx_start
        tbl[21] = mk(0, 0, 0, 16'd0, 0, 15, 1, 0, 1, 1);
        tbl[22] = mk(0, 1, 0, 16'd0, 0, 15, 1, 0, 1, 1);   // completes, IFG
        for (int i = 0; i < 23; i++) begin
            pct_qued = tbl[i].qued; pct_txed = tbl[i].txed;
            pause_valid = tbl[i].pv; pause_quanta = tbl[i].quanta;
            if (tbl[i].start_ofs > 0) exp_q.push_back(cyc + tbl[i].start_ofs);
            tick();
            clear_inputs();
            chk($sformatf("tbl%0d_pending", i), pending_cnt, tbl[i].e_pend);
            chk($sformatf("tbl%0d_busy", i), tx_busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_paused", i), paused, tbl[i].e_paused);
            chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].e_ovf);
            chk($sformatf("tbl%0d_proto_err", i), proto_err, tbl[i].e_perr);
        end

        // Single frame
        reset_dut();
        repeat (5) tick();
        n = cyc;
        pct_qued = 1;
        exp_q.push_back(n + 2);
        tick();
        pct_qued = 0;
        chk("single_pending1", pending_cnt, 1);
        tick();
        chk("single_busy_start", tx_busy, 1);
        tick();
        chk("single_pending0", pending_cnt, 0);
        while (cyc < n + 90) tick();
        t = cyc;
        pct_txed = 1;
        tick();
        pct_txed = 0;
        while (cyc < t + 12) tick();
        chk("single_busy_last_ifg", tx_busy, 1);
        tick();
        chk("single_busy_low", tx_busy, 0);
        chk("single_proto_err", proto_err, 0);

        // Back-to-back: three frames
        reset_dut();
        n = cyc;
        exp_q.push_back(n + 2);
        pct_qued = 1;
        repeat (3) tick();
        pct_qued = 0;
        s = n + 2;
        t = 0;
        for (int i = 0; i < 3; i++) begin
            while (cyc < s + 50) tick();
            t = cyc;
            pct_txed = 1;
            tick();
            pct_txed = 0;
            if (i < 2) begin
                s = t + 14;
                exp_q.push_back(s);
            end
        end
        while (cyc < t + 30) tick();
        chk("b2b_pending_end", pending_cnt, 0);
        chk("b2b_busy_end", tx_busy, 0);
        chk("b2b_starts_left", exp_q.size(), 0);
        chk("b2b_proto_err", proto_err, 0);

        // Pause of 2 quanta with a frame queued in the same cycle
        reset_dut();
        p = cyc;
        pause_valid = 1; pause_quanta = 16'd2; pct_qued = 1;
        tick();
        clear_inputs();
        chk("pause_high", paused, 1);
        chk("pause_pending", pending_cnt, 1);
        exp_q.push_back(p + 130);
        hi = 1;
        while (paused && hi < 300) begin
            tick();
            if (paused) hi++;
        end
        chk("pause_len", hi, 128);
        chk("pause_fall_cycle", cyc, p + 129);
        tick();
        tick();
        chk("pause_busy_after", tx_busy, 1);

        // Cancel mid-pause, then pause_valid coincident with the IDLE start decision
        reset_dut();
        pause_valid = 1; pause_quanta = 16'd5;
        tick();
        clear_inputs();
        repeat (10) tick();
        chk("cancel_before", paused, 1);
        pause_valid = 1; pause_quanta = 16'd0;
        tick();
        clear_inputs();
        chk("cancel_after", paused, 0);
        n = cyc;
        pct_qued = 1;
        exp_q.push_back(n + 2);
        tick();
        pct_qued = 0;
        pause_valid = 1; pause_quanta = 16'd3;
        tick();
        clear_inputs();
        chk("coinc_pause_busy", tx_busy, 1);
        chk("coinc_pause_paused", paused, 1);

        // Reset in ACTIVE with another frame pending
        reset_dut();
        n = cyc;
        pct_qued = 1;
        exp_q.push_back(n + 2);
        tick();
        tick();
        pct_qued = 0;
        tick();
        tick();
        chk("rstact_pending_pre", pending_cnt, 1);
        chk("rstact_busy_pre", tx_busy, 1);
        eth_rst = 1;
        tick();
        eth_rst = 0;
        chk("rstact_busy", tx_busy, 0);
        chk("rstact_pending", pending_cnt, 0);
        chk("rstact_tx_start", tx_start, 0);
        chk("rstact_paused", paused, 0);
        repeat (40) tick();
        chk("rstact_idle", tx_busy, 0);

`ifdef TX_WATCHDOG_EN
        // Watchdog: no completion, then the second queued frame starts normally
        reset_dut();
        n = cyc;
        pct_qued = 1;
        exp_q.push_back(n + 2);
        tick();
        tick();
        pct_qued = 0;
        exp_q.push_back(n + 1546);
        while (!timeout && cyc < n + 2000) tick();
        chk("wd_timeout", timeout, 1);
        chk("wd_cycle", cyc, n + 1533);
        chk("wd_busy_ifg", tx_busy, 1);
        while (cyc < n + 1550) tick();
        chk("wd_pending_end", pending_cnt, 0);
`else
        chk("no_wd_timeout", timeout, 0);
`endif

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_frame_sched.md
Name: tx_frame_sched

Overview:
- Single-clock transmit sequencer in the eth_tx_clk domain. It sits between the payload FIFO/buffer-ready logic and the encapsulation engine.
- Counts frames fully queued in the TX FIFO and issues one start pulse per frame to encapsulation.
- Enforces the IEEE 802.3 inter-frame gap and honours 802.3x PAUSE requests before starting a new frame.

Parameters:
- CNT_W, 4: width of the pending-frame counter; maximum pending is 2^CNT_W-1.
- IFG_CYCLES, 12: inter-frame gap in eth_tx_clk cycles (96 bit times at 8-bit GMII).
- PAUSE_QUANTUM_CYCLES, 64: cycles per pause quantum (512 bit times / 8); must be a power of two.
- MAX_FRAME_CYCLES, 1530: watchdog limit in the ACTIVE state (used only with the optional feature).

Ports:
- eth_tx_clk, in, 1: single clock.
- eth_rst, in, 1: synchronous, active-high reset.
- pct_qued, in, 1: one-cycle pulse; one complete frame has been written to the FIFO.
- pct_txed, in, 1: one-cycle pulse from encapsulation; the last FCS byte is on the wire.
- pause_valid, in, 1: one-cycle pulse; pause_quanta is valid.
- pause_quanta, in, 16: PAUSE time in quanta; 0 cancels any active pause.
- tx_start, out, 1: one-cycle pulse to encapsulation to begin a frame.
- tx_busy, out, 1: high in START, ACTIVE and IFG.
- paused, out, 1: pause counter is non-zero.
- pending_cnt, out, CNT_W: number of frames queued and not yet started.
- overflow, out, 1: sticky; pct_qued was received while pending_cnt was at maximum.
- proto_err, out, 1: sticky; pct_txed was received outside ACTIVE.
- timeout, out, 1: sticky; watchdog fired (optional feature only).

Behaviour:
- Reset: all outputs are 0, state is IDLE, all counters are 0.
- Reset wins over every other event in the same cycle, including mid-frame; no tx_start is issued after reset until a new pct_qued arrives.
- pending_cnt:
  - +1 on pct_qued; -1 on tx_start.
  - Both in the same cycle: unchanged.
  - pct_qued at maximum with no tx_start: count stays at maximum and overflow is set.
  - pending_cnt never underflows, because tx_start requires pending_cnt != 0.
- States: IDLE, START, ACTIVE, IFG.
  - IDLE: if pending_cnt != 0 and !paused, go to START; otherwise stay.
  - START: tx_start = 1 for exactly this cycle; go to ACTIVE unconditionally.
  - ACTIVE: wait for pct_txed, then go to IFG and load the gap counter with IFG_CYCLES-1.
  - IFG: decrement the gap counter each cycle; when it reaches 0, go to IDLE.
- Timing:
  - pct_qued in cycle N with pending 0 and not paused: pending_cnt=1 at N+1, START (tx_start high) at N+2.
  - pct_txed in cycle T: IFG occupies T+1..T+IFG_CYCLES, IDLE at T+IFG_CYCLES+1, next tx_start at T+IFG_CYCLES+2.
- Pause:
  - pause_valid loads pause_cnt = pause_quanta * PAUSE_QUANTUM_CYCLES (22-bit, implemented as a left shift).
  - pause_cnt decrements by 1 per cycle while non-zero; paused = (pause_cnt != 0).
  - A reload while already paused overwrites the remaining count; quanta=0 clears it immediately (paused low next cycle).
  - Pause is sampled only in IDLE. A frame in START/ACTIVE always completes, and IFG still runs.
  - pause_valid and the IDLE start decision in the same cycle: the start proceeds, because the decision uses the registered paused.
- proto_err: pct_txed in IDLE, START or IFG sets it; the state machine ignores the pulse.

Optional Feature:
- Macro: TX_WATCHDOG_EN.
- With the macro defined:
  - An 11-bit counter clears on entry to ACTIVE and increments each ACTIVE cycle.
  - When it reaches MAX_FRAME_CYCLES without pct_txed: go to IFG (normal gap load) and set timeout sticky.
  - pct_txed in the same cycle the limit is reached counts as normal completion; timeout is not set.
- Without the macro: no counter is instantiated, timeout is tied to 0, and ACTIVE waits indefinitely.

Decomposition:
- Package eth_tx_pkg holds:
  - the state enum tx_sched_state_t (IDLE, START, ACTIVE, IFG);
  - localparams IFG_BYTES=12, PAUSE_QUANTUM_BITS=512, MAX_FRAME_BYTES=1522;
  - the pause-count width constant.
- One sub-module, tx_pause_timer: inputs pause_valid and pause_quanta, outputs paused; owns the shift-load and decrement.

Test Plan:
- Single frame: pct_qued at cycle 10 -> tx_start pulse at cycle 12, pending_cnt 1→0; pct_txed at 100 -> tx_busy low from cycle 113.
- Back-to-back: 3 pct_qued pulses, then pct_txed 50 cycles after each start -> starts spaced exactly IFG_CYCLES+2 cycles after each pct_txed; pending_cnt ends at 0.
- Pause: pause_valid with quanta=2 in IDLE with pending=1 -> paused for 128 cycles, then tx_start 2 cycles after paused falls. Quanta=0 mid-pause -> paused low next cycle.
- Saturation and simultaneous events: 16 pct_qued pulses with no starts (CNT_W=4) -> pending_cnt=15, overflow=1. pct_qued coincident with tx_start -> count unchanged.
- Errors and reset: pct_txed in IDLE -> proto_err=1, state stays IDLE. eth_rst asserted in ACTIVE -> all outputs 0 the next cycle, no further tx_start.
- TX_WATCHDOG_EN: no pct_txed after a start -> timeout=1 after 1530 ACTIVE cycles, IFG entered, next queued frame starts normally.
